// File: rtl/rdc_log_pkg.sv
// rtl/rdc_log_pkg.sv - shared defaults, width helpers and record type for rdc_event_log
package rdc_log_pkg;

  localparam int unsigned DEF_N_CORES     = 4;
  localparam int unsigned DEF_CORE_EVENTS = 2;
  localparam int unsigned DEF_FIFO_DEPTH  = 8;
  localparam int unsigned DEF_TS_WIDTH    = 16;
  localparam int unsigned DEF_DROP_WIDTH  = 8;

  // Index width that never collapses to zero bits for a single-entry range.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Occupancy counter width: one extra bit so a full FIFO is representable.
  function automatic int unsigned cnt_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

  localparam int unsigned DEF_CORE_W = idx_w(DEF_N_CORES);
  localparam int unsigned DEF_EVT_W  = idx_w(DEF_CORE_EVENTS);

  // Logged record layout for the default configuration, MSB first.
  typedef struct packed {
    logic [DEF_CORE_W-1:0]   core;
    logic [DEF_EVT_W-1:0]    evt;
    logic [DEF_TS_WIDTH-1:0] ts;
  } rec_t;

endpackage

// File: rtl/rdc_log_fifo.sv
// rtl/rdc_log_fifo.sv - synchronous record FIFO with wrap-bit pointers
module rdc_log_fifo #(
  parameter int unsigned DW    = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [DW-1:0]            wdata_i,
  input  logic                     pop_i,
  output logic [DW-1:0]            rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] mem_d [DEPTH];
  logic [AW:0]   wptr_q, wptr_d;
  logic [AW:0]   rptr_q, rptr_d;
  logic          do_push, do_pop;

  // Status, accepted push/pop and next pointer/storage values; a push into a
  // full FIFO is accepted only when the head leaves in the same cycle.
  always_comb begin
    empty_o = (wptr_q == rptr_q);
    full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    do_pop  = pop_i & ~empty_o;
    do_push = push_i & (~full_o | do_pop);
    mem_d   = mem_q;
    if (do_push) begin
      mem_d[wptr_q[AW-1:0]] = wdata_i;
    end
    wptr_d  = wptr_q + (AW+1)'(do_push);
    rptr_d  = rptr_q + (AW+1)'(do_pop);
    count_o = wptr_q - rptr_q;
    rdata_o = mem_q[rptr_q[AW-1:0]];
  end

  // Pointer and storage registers, fully cleared on reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      mem_q  <= mem_d;
    end
  end

endmodule

// File: rtl/rdc_event_log.sv
// rtl/rdc_event_log.sv - logs newly raised RDC interrupt bits; timestamps built with RDC_LOG_TIMESTAMP_EN
module rdc_event_log
  import rdc_log_pkg::*;
#(
  parameter int unsigned N_CORES     = DEF_N_CORES,
  parameter int unsigned CORE_EVENTS = DEF_CORE_EVENTS,
  parameter int unsigned FIFO_DEPTH  = DEF_FIFO_DEPTH,
  parameter int unsigned TS_WIDTH    = DEF_TS_WIDTH,
  parameter int unsigned DROP_WIDTH  = DEF_DROP_WIDTH
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             enable_i,
  input  logic                             clear_i,
  input  logic [N_CORES*CORE_EVENTS-1:0]   irq_vector_i,
  output logic                             rec_valid_o,
  input  logic                             rec_ready_i,
  output logic [idx_w(N_CORES)-1:0]        rec_core_o,
  output logic [idx_w(CORE_EVENTS)-1:0]    rec_event_o,
  output logic [TS_WIDTH-1:0]              rec_ts_o,
  output logic [cnt_w(FIFO_DEPTH)-1:0]     count_o,
  output logic                             overflow_o,
  output logic [DROP_WIDTH-1:0]            drop_cnt_o,
  output logic                             irq_o
);

  localparam int unsigned N_BITS = N_CORES * CORE_EVENTS;
  localparam int unsigned CORE_W = idx_w(N_CORES);
  localparam int unsigned EVT_W  = idx_w(CORE_EVENTS);
`ifdef RDC_LOG_TIMESTAMP_EN
  localparam int unsigned REC_TS_W = TS_WIDTH;
`else
  localparam int unsigned REC_TS_W = 0;
`endif
  localparam int unsigned REC_W = CORE_W + EVT_W + REC_TS_W;

  logic [N_BITS-1:0]     prev_q, prev_d;
  logic [N_BITS-1:0]     pending_q, pending_d;
  logic [N_BITS-1:0]     rise, cand, grant;
  logic                  grant_vld;
  logic [CORE_W-1:0]     grant_core;
  logic [EVT_W-1:0]      grant_evt;
  logic                  overflow_q, overflow_d;
  logic [DROP_WIDTH-1:0] drop_cnt_q, drop_cnt_d;
  logic                  fifo_full, fifo_empty;
  logic                  pop, drop;
  logic [REC_W-1:0]      wdata, rdata;

  // Rising-edge detect, lowest-index grant and pending-mask update; the
  // descending scan lets the lowest set index overwrite earlier hits.
  always_comb begin
    rise       = irq_vector_i & ~prev_q & {N_BITS{enable_i}};
    cand       = pending_q | rise;
    grant      = '0;
    grant_vld  = 1'b0;
    grant_core = '0;
    grant_evt  = '0;
    for (int i = N_BITS - 1; i >= 0; i--) begin
      if (cand[i]) begin
        grant      = '0;
        grant[i]   = 1'b1;
        grant_vld  = 1'b1;
        grant_core = CORE_W'(i / int'(CORE_EVENTS));
        grant_evt  = EVT_W'(i % int'(CORE_EVENTS));
      end
    end
    prev_d    = enable_i ? irq_vector_i : '0;
    pending_d = enable_i ? (cand & ~grant) : '0;
  end

  // Drop detection and sticky overflow bookkeeping; clear wins over a drop.
  always_comb begin
    pop        = ~fifo_empty & rec_ready_i;
    drop       = grant_vld & fifo_full & ~pop;
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;
    if (clear_i) begin
      overflow_d = 1'b0;
      drop_cnt_d = '0;
    end else if (drop) begin
      overflow_d = 1'b1;
      if (drop_cnt_q != {DROP_WIDTH{1'b1}}) begin
        drop_cnt_d = drop_cnt_q + DROP_WIDTH'(1);
      end
    end
  end

`ifdef RDC_LOG_TIMESTAMP_EN
  logic [TS_WIDTH-1:0] ts_q, ts_d;

  // Free-running cycle stamp while enabled, held at zero otherwise.
  always_comb begin
    ts_d = enable_i ? (ts_q + TS_WIDTH'(1)) : '0;
  end

  // Timestamp register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ts_q <= '0;
    end else begin
      ts_q <= ts_d;
    end
  end

  assign wdata    = {grant_core, grant_evt, ts_q};
  assign rec_ts_o = rdata[TS_WIDTH-1:0];
`else
  assign wdata    = {grant_core, grant_evt};
  assign rec_ts_o = {TS_WIDTH{1'b0}};
`endif

  // Detector, pending mask and overflow state registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      prev_q     <= '0;
      pending_q  <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      prev_q     <= prev_d;
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  rdc_log_fifo #(
    .DW    (REC_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (grant_vld),
    .wdata_i (wdata),
    .pop_i   (pop),
    .rdata_o (rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (count_o)
  );

  assign rec_valid_o = ~fifo_empty;
  assign irq_o       = ~fifo_empty;
  assign rec_core_o  = rdata[REC_W-1 -: CORE_W];
  assign rec_event_o = rdata[REC_TS_W +: EVT_W];
  assign overflow_o  = overflow_q;
  assign drop_cnt_o  = drop_cnt_q;

endmodule

// File: tb/tb_rdc_event_log.sv
// tb/tb_rdc_event_log.sv - directed and random checks of rdc_event_log against a queue model; honours RDC_LOG_TIMESTAMP_EN
module tb_rdc_event_log;

  localparam int DEPTH = 8;
  localparam int TSW   = 4;

  logic       clk = 1'b0;
  logic       rst_i;
  logic       enable_i;
  logic       clear_i;
  logic [7:0] irq_vector_i;
  logic       rec_valid_o;
  logic       rec_ready_i;
  logic [1:0] rec_core_o;
  logic [0:0] rec_event_o;
  logic [3:0] rec_ts_o;
  logic [3:0] count_o;
  logic       overflow_o;
  logic [7:0] drop_cnt_o;
  logic       irq_o;

  int n_chk  = 0;
  int n_pass = 0;

  typedef struct {
    int core;
    int evt;
    int ts;
  } mrec_t;

  mrec_t    mq[$];
  bit [7:0] m_prev;
  bit [7:0] m_pend;
  int       m_ts;
  bit       m_ovf;
  int       m_drop;

  always #5 clk = ~clk;

  rdc_event_log #(
    .N_CORES     (4),
    .CORE_EVENTS (2),
    .FIFO_DEPTH  (DEPTH),
    .TS_WIDTH    (TSW),
    .DROP_WIDTH  (8)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .enable_i     (enable_i),
    .clear_i      (clear_i),
    .irq_vector_i (irq_vector_i),
    .rec_valid_o  (rec_valid_o),
    .rec_ready_i  (rec_ready_i),
    .rec_core_o   (rec_core_o),
    .rec_event_o  (rec_event_o),
    .rec_ts_o     (rec_ts_o),
    .count_o      (count_o),
    .overflow_o   (overflow_o),
    .drop_cnt_o   (drop_cnt_o),
    .irq_o        (irq_o)
  );

  function automatic int tsx(input int v);
`ifdef RDC_LOG_TIMESTAMP_EN
    return v;
`else
    return 0;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk = n_chk + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic void model_step(input bit en, input bit clr, input bit [7:0] vec,
                                     input bit rdy, input bit rst);
    bit [7:0] cand;
    int       g;
    bit       dropped;
    mrec_t    r;
    if (rst) begin
      mq.delete();
      m_prev = '0;
      m_pend = '0;
      m_ts   = 0;
      m_ovf  = 1'b0;
      m_drop = 0;
      return;
    end
    dropped = 1'b0;
    cand    = m_pend | (en ? (vec & ~m_prev) : 8'h00);
    g       = -1;
    for (int i = 0; i < 8; i++) begin
      if (cand[i] && g < 0) g = i;
    end
    if (rdy && mq.size() > 0) void'(mq.pop_front());
    if (g >= 0) begin
      if (mq.size() < DEPTH) begin
        r.core = g / 2;
        r.evt  = g % 2;
        r.ts   = m_ts;
        mq.push_back(r);
      end else begin
        dropped = 1'b1;
      end
      cand[g] = 1'b0;
    end
    if (clr) begin
      m_ovf  = 1'b0;
      m_drop = 0;
    end else if (dropped) begin
      m_ovf = 1'b1;
      if (m_drop < 255) m_drop = m_drop + 1;
    end
    m_pend = en ? cand : 8'h00;
    m_prev = en ? vec : 8'h00;
    m_ts   = en ? (m_ts + 1) % (1 << TSW) : 0;
  endfunction

  task automatic check_all();
    chk("valid", rec_valid_o, mq.size() > 0);
    chk("irq", irq_o, mq.size() > 0);
    chk("count", count_o, mq.size());
    chk("overflow", overflow_o, m_ovf);
    chk("drop_cnt", drop_cnt_o, m_drop);
    if (mq.size() > 0) begin
      chk("head_core", rec_core_o, mq[0].core);
      chk("head_event", rec_event_o, mq[0].evt);
      chk("head_ts", rec_ts_o, tsx(mq[0].ts));
    end
  endtask

  task automatic cyc(input bit en, input bit clr, input bit [7:0] vec, input bit rdy, input bit rst);
    enable_i     = en;
    clear_i      = clr;
    irq_vector_i = vec;
    rec_ready_i  = rdy;
    rst_i        = rst;
    model_step(en, clr, vec, rdy, rst);
    @(posedge clk);
    #1;
    check_all();
  endtask

  initial begin
    bit [7:0] rv;
    bit       ren;

    // reset state
    cyc(0, 0, 8'h00, 0, 1);
    cyc(0, 0, 8'h00, 0, 1);
    chk("rst_valid", rec_valid_o, 0);
    chk("rst_count", count_o, 0);
    chk("rst_irq", irq_o, 0);
    chk("rst_ovf", overflow_o, 0);
    chk("rst_drop", drop_cnt_o, 0);
    chk("rst_ts", rec_ts_o, 0);

    // single offender: bit 3 rises at enable cycle 10
    for (int i = 0; i < 10; i++) cyc(1, 0, 8'h00, 0, 0);
    cyc(1, 0, 8'h08, 0, 0);
    chk("s1_valid", rec_valid_o, 1);
    chk("s1_irq", irq_o, 1);
    chk("s1_core", rec_core_o, 1);
    chk("s1_event", rec_event_o, 1);
    chk("s1_ts", rec_ts_o, tsx(10));
    for (int i = 0; i < 20; i++) cyc(1, 0, 8'h08, 0, 0);
    chk("s1_hold_count", count_o, 1);
    cyc(1, 0, 8'h08, 1, 0);
    chk("s1_drained", count_o, 0);

    // simultaneous offenders 0, 5, 7 at enable cycle 32
    for (int i = 0; i < 3; i++) cyc(1, 0, 8'hA9, 0, 0);
    chk("s2_count", count_o, 3);
    chk("s2_h0_core", rec_core_o, 0);
    chk("s2_h0_event", rec_event_o, 0);
    chk("s2_h0_ts", rec_ts_o, tsx(0));
    cyc(1, 0, 8'hA9, 1, 0);
    chk("s2_h1_core", rec_core_o, 2);
    chk("s2_h1_event", rec_event_o, 1);
    chk("s2_h1_ts", rec_ts_o, tsx(1));
    cyc(1, 0, 8'hA9, 1, 0);
    chk("s2_h2_core", rec_core_o, 3);
    chk("s2_h2_event", rec_event_o, 1);
    chk("s2_h2_ts", rec_ts_o, tsx(2));
    cyc(1, 0, 8'hA9, 1, 0);
    chk("s2_empty", rec_valid_o, 0);

    // timestamp wrap: rise at enable cycle 17 with a 4-bit stamp
    cyc(0, 0, 8'h00, 0, 0);
    for (int i = 0; i < 17; i++) cyc(1, 0, 8'h00, 0, 0);
    cyc(1, 0, 8'h04, 0, 0);
    chk("wrap_core", rec_core_o, 1);
    chk("wrap_event", rec_event_o, 0);
    chk("wrap_ts", rec_ts_o, tsx(1));
    cyc(1, 0, 8'h04, 1, 0);

    // overflow, then clear
    cyc(0, 0, 8'h00, 0, 1);
    for (int i = 0; i < 10; i++) cyc(1, 0, 8'hFF, 0, 0);
    chk("ovf_full", count_o, 8);
    chk("ovf_none_yet", overflow_o, 0);
    cyc(0, 0, 8'h00, 0, 0);
    cyc(1, 0, 8'h01, 0, 0);
    chk("ovf_count", count_o, 8);
    chk("ovf_flag", overflow_o, 1);
    chk("ovf_drop", drop_cnt_o, 1);
    cyc(1, 1, 8'h01, 0, 0);
    chk("clr_flag", overflow_o, 0);
    chk("clr_drop", drop_cnt_o, 0);
    chk("clr_count", count_o, 8);

    // full FIFO with simultaneous push and pop
    cyc(0, 0, 8'h00, 0, 0);
    cyc(1, 0, 8'h40, 1, 0);
    chk("pp_count", count_o, 8);
    chk("pp_flag", overflow_o, 0);
    chk("pp_drop", drop_cnt_o, 0);
    chk("pp_head_core", rec_core_o, 0);
    chk("pp_head_event", rec_event_o, 1);
    for (int i = 0; i < 7; i++) cyc(1, 0, 8'h40, 1, 0);
    chk("pp_last_count", count_o, 1);
    chk("pp_last_core", rec_core_o, 3);
    chk("pp_last_event", rec_event_o, 0);
    chk("pp_last_ts", rec_ts_o, tsx(0));

    // reset with 4 queued and 2 pending
    cyc(0, 0, 8'h00, 0, 1);
    for (int i = 0; i < 4; i++) cyc(1, 0, 8'h3F, 0, 0);
    chk("mr_queued", count_o, 4);
    cyc(1, 0, 8'h3F, 0, 1);
    chk("mr_count", count_o, 0);
    chk("mr_valid", rec_valid_o, 0);
    for (int i = 0; i < 5; i++) cyc(1, 0, 8'h00, 0, 0);
    chk("mr_after_count", count_o, 0);
    chk("mr_after_valid", rec_valid_o, 0);

    // random traffic against the model
    rv = 8'h00;
    for (int i = 0; i < 600; i++) begin
      ren = ($urandom_range(0, 15) != 0);
      if (!ren) rv = 8'h00;
      else if ($urandom_range(0, 3) == 0) rv[$urandom_range(0, 7)] = ~rv[$urandom_range(0, 7)];
      cyc(ren, $urandom_range(0, 31) == 0, rv, $urandom_range(0, 2) == 0,
          $urandom_range(0, 249) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
